// File: rtl/fpu_issue_sequencer.sv
// Shares one FPU issue port between several pipelined functional units and retires
// their results strictly in issue order, accumulating sticky IEEE exception flags.
module fpu_issue_sequencer #(
   parameter int unsigned N_UNITS = 4,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   valid_in,
   output logic                   ready_out,
   input  logic [$clog2(N_UNITS)-1:0] unit_in,
   output logic [N_UNITS-1:0]     unit_valid_out,
   input  logic [N_UNITS-1:0]     unit_ready_in,
   output logic [N_UNITS-1:0]     unit_ready_out,
   input  logic [N_UNITS-1:0]     unit_valid_in,
   input  logic [N_UNITS*32-1:0]  unit_result,
   input  logic [N_UNITS*5-1:0]   unit_flags,
   output logic                   unit_flush,
   output logic                   valid_out,
   input  logic                   ready_in,
   output logic [31:0]            result_out,
   output logic [4:0]             flags_out,
   output logic [4:0]             fflags,
   input  logic                   fflags_clr,
   output logic                   busy
);

   localparam int unsigned UW = $clog2(N_UNITS);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [UW-1:0] fifo_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] outstanding_q [N_UNITS];
   logic [4:0]    fflags_q;

   logic          full, empty, unit_legal, issue, retire;
   logic [UW-1:0] head;

   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == '0);
   assign head       = fifo_q[rd_ptr_q];
   assign unit_legal = (32'(unit_in) < N_UNITS);

   // Issue side: full is the registered value, so a same-cycle retire never frees a slot.
   assign unit_flush = flush;
   assign ready_out  = !full && !flush && unit_legal && unit_ready_in[unit_in];
   assign issue      = valid_in && ready_out;

   always_comb begin
      unit_valid_out = '0;
      for (int i = 0; i < int'(N_UNITS); i++) begin
         unit_valid_out[i] = valid_in && !full && !flush && unit_legal && (unit_in == UW'(i));
      end
   end

   // Retire side: only the unit at the head of the order FIFO may hand over a result.
   assign valid_out  = !empty && !flush && unit_valid_in[head];
   assign retire     = valid_out && ready_in;
   assign result_out = empty ? '0 : unit_result[32*head +: 32];
   assign flags_out  = empty ? '0 : unit_flags[5*head +: 5];

   // Idle units always see ready so units with ready_in tied to ready_out can still accept.
   always_comb begin
      unit_ready_out = '0;
      for (int i = 0; i < int'(N_UNITS); i++) begin
         unit_ready_out[i] = (!empty && (head == UW'(i)) && ready_in) ||
                             (outstanding_q[i] == '0);
      end
   end

   assign busy   = !empty;
   assign fflags = fflags_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         fflags_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_q[i] <= '0;
         end
         for (int i = 0; i < int'(N_UNITS); i++) begin
            outstanding_q[i] <= '0;
         end
      end else begin
         if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(N_UNITS); i++) begin
               outstanding_q[i] <= '0;
            end
         end else begin
            if (issue) begin
               fifo_q[wr_ptr_q] <= unit_in;
               wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (retire) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (issue && !retire) begin
               count_q <= count_q + 1'b1;
            end else if (retire && !issue) begin
               count_q <= count_q - 1'b1;
            end
            for (int i = 0; i < int'(N_UNITS); i++) begin
               if (issue && (unit_in == UW'(i)) && !(retire && (head == UW'(i)))) begin
                  outstanding_q[i] <= outstanding_q[i] + 1'b1;
               end else if (retire && (head == UW'(i)) && !(issue && (unit_in == UW'(i)))) begin
                  outstanding_q[i] <= outstanding_q[i] - 1'b1;
               end
            end
         end
         // Clear takes effect before the retiring op's flags are merged in.
         if (retire) begin
            fflags_q <= (fflags_clr ? 5'b0 : fflags_q) | flags_out;
         end else if (fflags_clr) begin
            fflags_q <= '0;
         end
      end
   end

endmodule
